etc_th_pixel_emitter: RTL and testbench
=======================================

# etc_th_pixel_emitter

Downstream neighbour of the T/H-mode base-colour decoder. Captures the four paint colours and the 32 pixel-index bits of a T- or H-mode ETC2 block. Buffers up to two blocks in a ping-pong store. Emits the 16 decoded texels one per cycle on a valid/ready stream toward the texel writer.

## Interface
Parameters:
- none; all widths are fixed by the ETC2 format.

Ports:
- sclk  in  1  clock; all logic is on the rising edge
- rsrt  in  1  reset; synchronous, active-low
- color_rtr  out  1  credit to the upstream decoder: it may drive its `rtr` this cycle
- color_rts  in  1  upstream colour set valid; one-cycle pulse
- baseColor_0..baseColor_3  in  24 each  paint colours 0..3, as R[7:0], G[15:8], B[23:16]; sampled when color_rts=1
- pix_idx  in  32  block bits [31:0], delayed by the integrator to align with color_rts
- pix_valid  out  1  texel valid
- pix_ready  in  1  downstream accepts the texel when pix_valid && pix_ready
- pix_rgb  out  24  texel colour
- pix_x, pix_y  out  2 each  texel coordinates within the block
- pix_last  out  1  marks texel 15 of the block
- ovf_err  out  1  sticky protocol-violation flag

## Operation
- **Storage.** Two slots, each holding 4×24 colour bits plus 32 index bits. There is a write pointer `wp`, a read pointer `rp` and a 2-bit occupancy `occ` (0..2).
- **Credit.** `rtr_q` is `color_rtr` registered. `color_rtr = rsrt && (occ + rtr_q < 2)`.
  - A granted rtr returns color_rts one cycle later, so a slot is reserved one cycle ahead.
  - If the upstream block's mode was not T/H, color_rts never arrives; the reservation lapses after one cycle.
- **Capture.** On color_rts=1 with occ<2: write the slot at `wp`, toggle `wp`, occ+1.
- **Overflow.** On color_rts=1 with occ==2: discard the data and set `ovf_err`. `ovf_err` clears only on reset.
- **Emission.** A 4-bit texel counter `i` walks the slot at `rp`.
  - Paint index = {pix_idx[16+i], pix_idx[i]}. pix_rgb = baseColor selected by that index (0..3 maps directly).
  - pix_x = i[3:2], pix_y = i[1:0] (column-major ETC order). pix_last = (i==15).
- **Advance.** On a handshake, i+1. When i==15 the handshake also sets i to 0, toggles `rp` and decrements occ.
- **Simultaneous events.** Capture and final-texel release in the same cycle leave occ unchanged. Both pointers move.
- **States.** EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
  - Transitions follow occ. pix_valid = (occ≠0).
- **Backpressure.** With pix_ready=0, all pix_* outputs hold stable and i does not advance.
- **Reset values.** color_rtr=0 while rsrt=0. occ=0, wp=rp=0, i=0, rtr_q=0, ovf_err=0. pix_valid=0, pix_rgb=0, pix_x=pix_y=0, pix_last=0.
  - A reset mid-block drops all buffered data.
  - color_rtr rises in the first cycle with rsrt=1.

## Timing
- **Capture latency.** color_rts in cycle N puts texel 0 on pix_* in cycle N+1, provided the slot becomes head.
- **Throughput.** 16 cycles per block with pix_ready held high. Back-to-back blocks have no bubble: texel 15 of block A in cycle M is followed by texel 0 of block B in M+1 when B is buffered.
- **Output path.** pix_* are registered-state driven, with only a 4:1 colour mux after registers. There is no combinational path from pix_ready or color_rts to any output.
- **color_rtr** depends only on registered state and rsrt.

## Test plan
- **Reset.** Hold rsrt=0 for 3 cycles with color_rts=1 -> color_rtr=0, pix_valid=0, ovf_err=0. After release, color_rtr=1 in the first cycle.
- **Single block.** Colours 0x0000FF, 0x00FF00, 0xFF0000, 0xFFFFFF; pix_idx=0xFF00_F0F0; pix_ready=1.
  - Texels 0–3 have index 0 and emit 0x0000FF.
  - Texels 4–7 have index 1 and emit 0x00FF00.
  - Texels 8–11 have index 2 and emit 0xFF0000.
  - Texels 12–15 have index 3 and emit 0xFFFFFF.
  - x/y = i[3:2]/i[1:0]; pix_last only on texel 15; texel 0 one cycle after color_rts.
- **Back-to-back.** Two blocks, pix_ready=1 -> 32 consecutive valid cycles with no gap. occ never exceeds 2. color_rtr drops while two slots are reserved.
- **Backpressure.** Toggle pix_ready at random during texel 7 -> pix_rgb/pix_x/pix_y hold stable. The total texel count is 16, in order.
- **Overflow.** Force color_rts with occ=2 -> ovf_err=1 and stays 1. The buffered blocks are emitted unchanged.
- **Reset mid-block.** Pulse rsrt=0 at texel 9 -> next cycle pix_valid=0 and occ=0. No stale texels appear afterwards.

Source files
------------

// File: rtl/etc_th_pixel_emitter.sv
// ---------------------------------------------------------------------------
// etc_th_pixel_emitter
//
// Sits after the T/H-mode base-colour decoder. It captures the four paint
// colours and the 32 pixel-index bits of one ETC2 T/H block into a two-slot
// ping-pong store. It then emits the 16 decoded texels of each block, one per
// cycle, on a valid/ready stream toward the texel writer.
//
// Ports
//   sclk                 clock, rising edge
//   rsrt                 synchronous active-low reset
//   color_rtr            credit to upstream: it may raise its rtr this cycle
//   color_rts            one-cycle pulse, colour set + index bits valid
//   baseColor_0..3 [23:0] paint colours {B,G,R}
//   pix_idx       [31:0] block index bits, aligned with color_rts
//   pix_valid/pix_ready  texel handshake
//   pix_rgb       [23:0] texel colour
//   pix_x, pix_y  [1:0]  texel coordinates (column-major: x=i[3:2], y=i[1:0])
//   pix_last             texel 15 of the block
//   ovf_err              sticky: color_rts arrived while both slots were full
// ---------------------------------------------------------------------------
module etc_th_pixel_emitter (
  input  logic        sclk,
  input  logic        rsrt,
  output logic        color_rtr,
  input  logic        color_rts,
  input  logic [23:0] baseColor_0,
  input  logic [23:0] baseColor_1,
  input  logic [23:0] baseColor_2,
  input  logic [23:0] baseColor_3,
  input  logic [31:0] pix_idx,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [1:0]  pix_x,
  output logic [1:0]  pix_y,
  output logic        pix_last,
  output logic        ovf_err
);

  // Occupancy is the state: the encoding equals the number of full slots.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_wp;
  logic        r_rp;
  logic [3:0]  r_i;
  logic        r_rtr_q;
  logic        r_ovf;

  logic [23:0] r_col [0:1][0:3];
  logic [31:0] r_idx [0:1];

  logic [1:0]  w_occ;
  logic        w_cap;
  logic        w_ovf;
  logic        w_hs;
  logic        w_rel;
  logic [31:0] w_head_idx;
  logic [1:0]  w_paint;

  assign w_occ = r_state;
  assign w_cap = color_rts && (r_state != ST_FULL);
  assign w_ovf = color_rts && (r_state == ST_FULL);
  assign w_hs  = pix_valid && pix_ready;
  assign w_rel = w_hs && (r_i == 4'd15);

  // A granted credit is answered one cycle later, so the previous cycle's
  // grant still counts as an occupied slot. A lapsed grant (non-T/H block)
  // simply frees the reservation one cycle on.
  assign color_rtr = rsrt && (({1'b0, w_occ} + {2'b00, r_rtr_q}) < 3'd2);

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (!rsrt) begin
      r_state <= ST_EMPTY;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_i     <= 4'd0;
      r_rtr_q <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rtr_q <= color_rtr;
      if (w_cap) r_wp <= ~r_wp;
      if (w_ovf) r_ovf <= 1'b1;
      if (w_hs) begin
        r_i <= r_i + 4'd1;        // wraps 15 -> 0 at the end of a block
        if (w_rel) r_rp <= ~r_rp;
      end
    end
  end

  // ---------------- next state / outputs ----------------
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    pix_valid   = (r_state != ST_EMPTY);
    unique case (r_state)
      ST_EMPTY: if (w_cap) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_cap && !w_rel)      w_state_nxt = ST_FULL;
        else if (w_rel && !w_cap) w_state_nxt = ST_EMPTY;
      end
      // No capture is possible from FULL, so a release always drops to ONE.
      ST_FULL:  if (w_rel) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // ---------------- block store ----------------
  // NOTE: the slot store has no reset; a slot is only read once occupancy
  // says it was written, so clearing it would add logic without effect.
  always_ff @(posedge sclk) begin
    if (rsrt && w_cap) begin
      r_col[r_wp][0] <= baseColor_0;
      r_col[r_wp][1] <= baseColor_1;
      r_col[r_wp][2] <= baseColor_2;
      r_col[r_wp][3] <= baseColor_3;
      r_idx[r_wp]    <= pix_idx;
    end
  end

  // ---------------- texel decode ----------------
  // Paint index for texel i is {bit 16+i, bit i}; {1'b1, i} is exactly 16+i.
  assign w_head_idx = r_idx[r_rp];
  assign w_paint    = {w_head_idx[{1'b1, r_i}], w_head_idx[{1'b0, r_i}]};

  // Empty store reads as zero so the idle output is clean after reset.
  assign pix_rgb  = pix_valid ? r_col[r_rp][w_paint] : 24'd0;
  assign pix_x    = r_i[3:2];
  assign pix_y    = r_i[1:0];
  assign pix_last = (r_i == 4'd15);
  assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_etc_th_pixel_emitter.sv
// ---------------------------------------------------------------------------
// tb_etc_th_pixel_emitter
//
// Directed bench for etc_th_pixel_emitter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Expected texels
// come from a small paint-index model over the block table below.
// ---------------------------------------------------------------------------
module tb_etc_th_pixel_emitter;

  logic        sclk = 1'b0;
  logic        rsrt;
  logic        color_rtr;
  logic        color_rts;
  logic [23:0] baseColor_0, baseColor_1, baseColor_2, baseColor_3;
  logic [31:0] pix_idx;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb;
  logic [1:0]  pix_x, pix_y;
  logic        pix_last;
  logic        ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Block table: 0 single/backpressure, 1-2 back-to-back, 3-4 overflow kept,
  // 5 overflow discarded, 6 reset mid-block.
  logic [23:0] exp_col [0:6][0:3];
  logic [31:0] exp_idx [0:6];

  always #5 sclk = ~sclk;

  etc_th_pixel_emitter dut (
    .sclk        (sclk),
    .rsrt        (rsrt),
    .color_rtr   (color_rtr),
    .color_rts   (color_rts),
    .baseColor_0 (baseColor_0),
    .baseColor_1 (baseColor_1),
    .baseColor_2 (baseColor_2),
    .baseColor_3 (baseColor_3),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_rgb     (pix_rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_last    (pix_last),
    .ovf_err     (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int b, input int t);
    logic [31:0] w;
    logic [1:0]  p;
    w = exp_idx[b];
    p = {w[16 + t], w[t]};
    return exp_col[b][p];
  endfunction

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic load(input int b);
    baseColor_0 = exp_col[b][0];
    baseColor_1 = exp_col[b][1];
    baseColor_2 = exp_col[b][2];
    baseColor_3 = exp_col[b][3];
    pix_idx     = exp_idx[b];
    color_rts   = 1'b1;
  endtask

  // Consume nblk blocks starting at table entry b0, expecting a valid texel
  // every cycle. With bp set, pix_ready toggles randomly while texel 7 shows.
  task automatic stream(input int b0, input int nblk, input bit bp);
    int k, cyc, stalls, b, t;
    bit hold;
    logic [23:0] h_rgb;
    logic [1:0]  h_x, h_y;
    k = 0; cyc = 0; stalls = 0; hold = 1'b0;
    h_rgb = '0; h_x = '0; h_y = '0;
    while (k < nblk * 16 && cyc < 400) begin
      if (bp && (k % 16) == 7 && stalls < 6) pix_ready = 1'($urandom_range(0, 1));
      else pix_ready = 1'b1;
      @(negedge sclk);
      check("valid", 32'(pix_valid), 32'd1);
      if (pix_valid) begin
        b = b0 + k / 16;
        t = k % 16;
        check($sformatf("rgb b%0d t%0d", b, t), 32'(pix_rgb), 32'(exp_rgb(b, t)));
        check($sformatf("x t%0d", t), 32'(pix_x), 32'((t >> 2) & 3));
        check($sformatf("y t%0d", t), 32'(pix_y), 32'(t & 3));
        check($sformatf("last t%0d", t), 32'(pix_last), 32'(t == 15));
        if (hold) begin
          check("hold_rgb", 32'(pix_rgb), 32'(h_rgb));
          check("hold_x", 32'(pix_x), 32'(h_x));
          check("hold_y", 32'(pix_y), 32'(h_y));
        end
        hold  = !pix_ready;
        h_rgb = pix_rgb; h_x = pix_x; h_y = pix_y;
        if (pix_ready) begin k++; stalls = 0; end
        else stalls++;
      end
      step();
      cyc++;
    end
    check("texel_count", 32'(k), 32'(nblk * 16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    exp_col[0] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}; exp_idx[0] = 32'hFF00_F0F0;
    exp_col[1] = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678}; exp_idx[1] = 32'h1B2E_C3A5;
    exp_col[2] = '{24'hA5A5A5, 24'h5A5A5A, 24'h0F0F0F, 24'hF0F0F0}; exp_idx[2] = 32'h6C39_39C6;
    exp_col[3] = '{24'h010101, 24'h020202, 24'h030303, 24'h040404}; exp_idx[3] = 32'h0F0F_3355;
    exp_col[4] = '{24'hC0FFEE, 24'hBADA55, 24'h0DDBA1, 24'hFACADE}; exp_idx[4] = 32'hA5A5_5A5A;
    exp_col[5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444}; exp_idx[5] = 32'hFFFF_FFFF;
    exp_col[6] = '{24'h0A0B0C, 24'h102030, 24'h405060, 24'h708090}; exp_idx[6] = 32'h0000_FFFF;

    rsrt = 1'b0; color_rts = 1'b1; pix_ready = 1'b1;
    baseColor_0 = '0; baseColor_1 = '0; baseColor_2 = '0; baseColor_3 = '0; pix_idx = '0;

    // ---- reset: 3 cycles with color_rts asserted ----
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge sclk);
      check("rst_rtr", 32'(color_rtr), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_ovf", 32'(ovf_err), 32'd0);
    end
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    step();
    rsrt = 1'b1; color_rts = 1'b0;
    @(negedge sclk);
    check("rel_rtr_first_cycle", 32'(color_rtr), 32'd1);
    check("rel_valid", 32'(pix_valid), 32'd0);

    // ---- single block; texel 0 one cycle after color_rts ----
    step();
    load(0);
    @(negedge sclk);
    check("single_pre_valid", 32'(pix_valid), 32'd0);
    step();
    color_rts = 1'b0;
    stream(0, 1, 1'b0);
    @(negedge sclk);
    check("single_done_valid", 32'(pix_valid), 32'd0);

    // ---- back-to-back: two captures, 32 gapless texels ----
    step();
    pix_ready = 1'b0;
    @(negedge sclk);
    check("b2b_rtr_idle", 32'(color_rtr), 32'd1);
    step();
    load(1);
    step();
    load(2);
    @(negedge sclk);
    check("b2b_rtr_reserved", 32'(color_rtr), 32'd0);
    step();
    color_rts = 1'b0;
    @(negedge sclk);
    check("b2b_rtr_full", 32'(color_rtr), 32'd0);
    step();
    stream(1, 2, 1'b0);
    @(negedge sclk);
    check("b2b_done_valid", 32'(pix_valid), 32'd0);

    // ---- backpressure on texel 7 ----
    step();
    load(0);
    step();
    color_rts = 1'b0;
    stream(0, 1, 1'b1);

    // ---- overflow: third color_rts while both slots are full ----
    pix_ready = 1'b0;
    load(3);
    step();
    load(4);
    step();
    load(5);
    @(negedge sclk);
    check("ovf_before", 32'(ovf_err), 32'd0);
    step();
    color_rts = 1'b0;
    @(negedge sclk);
    check("ovf_set", 32'(ovf_err), 32'd1);
    step();
    stream(3, 2, 1'b0);
    @(negedge sclk);
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("ovf_no_extra_block", 32'(pix_valid), 32'd0);

    // ---- reset mid-block at texel 9 ----
    step();
    load(6);
    step();
    color_rts = 1'b0;
    pix_ready = 1'b1;
    for (int c = 0; c < 9; c++) step();
    @(negedge sclk);
    check("mid_pre_rgb", 32'(pix_rgb), 32'(exp_rgb(6, 9)));
    check("mid_pre_xy", 32'({pix_x, pix_y}), 32'(4'd9));
    step();
    rsrt = 1'b0;
    @(negedge sclk);
    check("mid_rst_rtr", 32'(color_rtr), 32'd0);
    step();
    rsrt = 1'b1;
    @(negedge sclk);
    check("mid_after_valid", 32'(pix_valid), 32'd0);
    check("mid_after_rgb", 32'(pix_rgb), 32'd0);
    check("mid_after_ovf", 32'(ovf_err), 32'd0);
    check("mid_after_xy", 32'({pix_x, pix_y}), 32'd0);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge sclk);
      if (pix_valid) nv++;
    end
    check("mid_no_stale", 32'(nv), 32'd0);
    check("mid_rtr_back", 32'(color_rtr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
